// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for call/ret.
// Define PC_STACK_ERR_EN to build the sticky stack-fault flag on err.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       countdown,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [WIDTH-1:0] ret_addr;
  logic             push;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (depth_reg == DW'(DEPTH));
  assign is_empty = (depth_reg == '0);
  assign top_idx  = AW'(depth_reg - DW'(1));
  assign push_idx = depth_reg[AW-1:0];
  // Return address wraps naturally, so a call from all-ones pushes zero.
  assign ret_addr = pc_reg + WIDTH'(1);

  // One action per cycle: load > call > ret > tick.
  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    push       = 1'b0;
    if (load) begin
      pc_next = in;
    end else if (call) begin
      if (!is_full) begin
        push       = 1'b1;
        pc_next    = in;
        depth_next = depth_reg + DW'(1);
      end
    end else if (ret) begin
      if (!is_empty) begin
        pc_next    = stack_mem[top_idx];
        depth_next = depth_reg - DW'(1);
      end
    end else if (tick) begin
      pc_next = countdown ? (pc_reg - WIDTH'(1)) : (pc_reg + WIDTH'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= '0;
      depth_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
    end
  end

  // Storage is never cleared; entries above depth are unobservable.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_mem[push_idx] <= ret_addr;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic err_reg;
  logic fault;

  assign fault = !load && ((call && is_full) || (!call && ret && is_empty));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (fault) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign out   = pc_reg;
  assign depth = depth_reg;
  assign full  = is_full;
  assign empty = is_empty;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: directed steps push expectations, a monitor checks each cycle.
module tb_pc_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, tick, countdown, load, call, ret;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [3:0]       depth;
  logic             full, empty, err;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick), .countdown(countdown),
    .load(load), .call(call), .ret(ret), .in(in),
    .out(out), .depth(depth), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] o;
    logic [3:0]  d;
    logic        f;
    logic        e;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic err_m = 1'b0;

  // Monitor: the DUT presents a fresh state every cycle; check it on the falling edge.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if (out !== x.o || depth !== x.d || full !== x.f || empty !== x.e || err !== x.er) begin
        bad++;
        $display("FAIL %s: got out=%h depth=%0d full=%b empty=%b err=%b, expected out=%h depth=%0d full=%b empty=%b err=%b",
                 x.nm, out, depth, full, empty, err, x.o, x.d, x.f, x.e, x.er);
      end else begin
        $display("txn %s: out=%h depth=%0d full=%b empty=%b err=%b ok",
                 x.nm, out, depth, full, empty, err);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic l, input logic c,
                      input logic rt, input logic t, input logic cd, input logic [15:0] d,
                      input logic [15:0] eo, input logic [3:0] ed, input logic fault);
    exp_t x;
    reset = r; load = l; call = c; ret = rt; tick = t; countdown = cd; in = d;
    @(posedge clk);
    #1;
    if (r) err_m = 1'b0;
    else if (fault && ERR_EN) err_m = 1'b1;
    x.nm = nm; x.o = eo; x.d = ed;
    x.f = (ed == 4'd8); x.e = (ed == 4'd0); x.er = err_m;
    sb.push_back(x);
    reset = 0; load = 0; call = 0; ret = 0; tick = 0; countdown = 0; in = '0;
  endtask

  function automatic logic [15:0] tgt(input int k);
    return 16'h1000 + 16'(k) * 16'h0010;
  endfunction

  initial begin
    reset = 1; tick = 0; countdown = 0; load = 0; call = 0; ret = 0; in = '0;
    //          name          r  l  c  rt t  cd in        out       dep  fault
    step("reset",           1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0);
    step("up1",             0, 0, 0, 0, 1, 0, 16'h0000, 16'h0001, 4'd0, 0);
    step("up2",             0, 0, 0, 0, 1, 0, 16'h0000, 16'h0002, 4'd0, 0);
    step("up3",             0, 0, 0, 0, 1, 0, 16'h0000, 16'h0003, 4'd0, 0);
    step("dn1",             0, 0, 0, 0, 1, 1, 16'h0000, 16'h0002, 4'd0, 0);
    step("dn2",             0, 0, 0, 0, 1, 1, 16'h0000, 16'h0001, 4'd0, 0);
    step("dn3",             0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 4'd0, 0);
    step("dn_wrap",         0, 0, 0, 0, 1, 1, 16'h0000, 16'hFFFF, 4'd0, 0);
    step("idle_hold",       0, 0, 0, 0, 0, 0, 16'h5555, 16'hFFFF, 4'd0, 0);
    step("up_wrap",         0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 4'd0, 0);
    step("load10",          0, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 4'd0, 0);
    step("call200",         0, 0, 1, 0, 0, 0, 16'h0200, 16'h0200, 4'd1, 0);
    step("ret11",           0, 0, 0, 1, 0, 0, 16'h0000, 16'h0011, 4'd0, 0);
    step("load42",          0, 1, 0, 0, 0, 0, 16'h0042, 16'h0042, 4'd0, 0);
    step("ret_empty",       0, 0, 0, 1, 0, 0, 16'h0000, 16'h0042, 4'd0, 1);
    step("idle_err_hold",   0, 0, 0, 0, 0, 0, 16'h0000, 16'h0042, 4'd0, 0);
    step("reset2",          1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0);

    // Fill the stack, overflow once, then unwind in LIFO order.
    for (int k = 0; k < DEPTH; k++)
      step($sformatf("call_n%0d", k), 0, 0, 1, 0, 0, 0, tgt(k), tgt(k), 4'(k + 1), 0);
    step("call_full",       0, 0, 1, 0, 0, 0, 16'h1234, tgt(7), 4'd8, 1);
    for (int j = 0; j < DEPTH; j++)
      step($sformatf("ret_n%0d", j), 0, 0, 0, 1, 0, 0, 16'h0000,
           (j < 7) ? tgt(6 - j) + 16'h0001 : 16'h0001, 4'(7 - j), 0);

    step("reset3",          1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0, 0);
    step("loadFFFF",        0, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 4'd0, 0);
    step("call_from_ones",  0, 0, 1, 0, 0, 0, 16'h0050, 16'h0050, 4'd1, 0);
    step("ret_to_zero",     0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 4'd0, 0);
    step("load_call_tick",  0, 1, 1, 0, 1, 0, 16'h0300, 16'h0300, 4'd0, 0);
    step("call_ret",        0, 0, 1, 1, 0, 0, 16'h0400, 16'h0400, 4'd1, 0);
    step("call_tick_dn",    0, 0, 1, 0, 1, 1, 16'h0500, 16'h0500, 4'd2, 0);
    step("ret401",          0, 0, 0, 1, 0, 0, 16'h0000, 16'h0401, 4'd1, 0);
    step("ret_tick",        0, 0, 0, 1, 1, 0, 16'h0000, 16'h0301, 4'd0, 0);
    step("ret_empty2",      0, 0, 0, 1, 0, 0, 16'h0000, 16'h0301, 4'd0, 1);
    step("call_a",          0, 0, 1, 0, 0, 0, 16'h0010, 16'h0010, 4'd1, 0);
    step("call_b",          0, 0, 1, 0, 0, 0, 16'h0020, 16'h0020, 4'd2, 0);
    step("call_c",          0, 0, 1, 0, 0, 0, 16'h0030, 16'h0030, 4'd3, 0);
    step("reset_over_call", 1, 0, 1, 0, 0, 0, 16'h0777, 16'h0000, 4'd0, 0);
    step("post_reset_up",   0, 0, 0, 0, 1, 0, 16'h0000, 16'h0001, 4'd0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
